// File: rtl/vfb_ui_pkg.sv
// Shared definitions for the frame-buffer UI responder.
//   CMD_WR / CMD_RD : UI command codes
//   ui_state_t      : responder FSM state encoding
//   beat_shift()    : log2 of address units per data beat
package vfb_ui_pkg;

   localparam logic [2:0] CMD_WR = 3'b000;
   localparam logic [2:0] CMD_RD = 3'b001;

   typedef enum logic [1:0] {
      ST_CALIB = 2'd0,
      ST_IDLE  = 2'd1,
      ST_WRITE = 2'd2,
      ST_READ  = 2'd3
   } ui_state_t;

   function automatic int beat_shift(input int data_width, input int dq_width);
      int ratio;
      int s;
      ratio = data_width / dq_width;
      s = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < ratio) s = i + 1;
      end
      return s;
   endfunction

endpackage

// File: rtl/ui_bram_be.sv
// Simple dual-port RAM with per-byte write enables and a registered read.
// Ports:
//   clk            : clock
//   rst_n          : async active-low reset (clears the read register only)
//   we/waddr/wbe/wdata : write port, wbe bit b enables byte b
//   re/raddr       : read request; rdata updates on the next edge
//   rdata          : read register, holds its value while re is low
module ui_bram_be #(
   parameter int DATA_WIDTH = 128,
   parameter int AW         = 10
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    we,
   input  logic [AW-1:0]           waddr,
   input  logic [DATA_WIDTH/8-1:0] wbe,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic                    re,
   input  logic [AW-1:0]           raddr,
   output logic [DATA_WIDTH-1:0]   rdata
);

   localparam int NB = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem [0:(1<<AW)-1];

   // Array contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < NB; b++) begin
            if (wbe[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/ddr_ui_responder.sv
// Responder end of the frame-buffer DDR user interface, backed by on-chip RAM.
// Stands in for the DDR3 controller during bring-up and simulation.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CALIB | calibration timer running, then one cycle with calib done
// ST_IDLE  | cmd_ready=1, waiting for a command
// ST_WRITE | taking len+1 write beats (throttled by I_stall)
// ST_READ  | latency wait, len+1 read beats, one trailing cycle
//
// Ports:
//   I_dma_clk, I_rst_n   : clock, async active-low reset
//   I_stall              : forces wr_data_rdy low
//   cmd, cmd_en, app_burst_number, addr, cmd_ready : command channel
//   wr_data_en, wr_data_end, wr_data, wr_data_mask, wr_data_rdy : write channel
//   rd_data_valid, rd_data_end, rd_data : read channel
//   init_calib_complete  : calibration done
//   O_proto_err          : sticky protocol-error flag
module ddr_ui_responder
   import vfb_ui_pkg::*;
#(
   parameter int ADDR_WIDTH   = 26,
   parameter int DATA_WIDTH   = 128,
   parameter int DQ_WIDTH     = 16,
   parameter int MEM_AW       = 10,
   parameter int CALIB_CYCLES = 64,
   parameter int RD_LATENCY   = 4
) (
   input  logic                    I_dma_clk,
   input  logic                    I_rst_n,
   input  logic                    I_stall,
   input  logic [2:0]              cmd,
   input  logic                    cmd_en,
   input  logic [5:0]              app_burst_number,
   input  logic [ADDR_WIDTH-1:0]   addr,
   output logic                    cmd_ready,
   input  logic                    wr_data_en,
   input  logic                    wr_data_end,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic [DATA_WIDTH/8-1:0] wr_data_mask,
   output logic                    wr_data_rdy,
   output logic                    rd_data_valid,
   output logic                    rd_data_end,
   output logic [DATA_WIDTH-1:0]   rd_data,
   output logic                    init_calib_complete,
   output logic                    O_proto_err
);

   localparam int BEAT_SHIFT = beat_shift(DATA_WIDTH, DQ_WIDTH);
   localparam int CW         = $clog2(CALIB_CYCLES) + 1;
   localparam int RW         = $clog2(RD_LATENCY) + 1;
   localparam logic [CW-1:0] CALIB_LOAD = CW'(CALIB_CYCLES - 1);
   // One cycle of the read latency is the RAM's own output register.
   localparam logic [RW-1:0] RD_WAIT_LOAD = RW'(RD_LATENCY - 1);

   ui_state_t state, state_next;

   logic [CW-1:0]     calib_cnt;
   logic [MEM_AW-1:0] base;
   logic [5:0]        len;
   logic [5:0]        cnt;
   logic [RW-1:0]     rd_wait;
   logic [MEM_AW-1:0] beat_addr;

   logic cmd_acc;
   logic wr_beat;
   logic rd_issue;
   logic err_set;
   logic last_beat;

   // Only the beat-index bits of addr select RAM rows.
   logic unused_addr;
   assign unused_addr = ^{addr[ADDR_WIDTH-1:BEAT_SHIFT+MEM_AW], addr[BEAT_SHIFT-1:0]};

   assign beat_addr = base + MEM_AW'(cnt);
   assign last_beat = (cnt == len);

   always_comb begin
      state_next  = state;
      cmd_ready   = 1'b0;
      wr_data_rdy = 1'b0;
      cmd_acc     = 1'b0;
      wr_beat     = 1'b0;
      rd_issue    = 1'b0;
      err_set     = 1'b0;
      case (state)
         ST_CALIB: begin
            // Leaving one cycle after calib rises keeps cmd_ready low that cycle.
            if (init_calib_complete) state_next = ST_IDLE;
         end
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_en) begin
               if (cmd == CMD_WR) begin
                  cmd_acc    = 1'b1;
                  state_next = ST_WRITE;
               end else if (cmd == CMD_RD) begin
                  cmd_acc    = 1'b1;
                  state_next = ST_READ;
               end else begin
                  err_set = 1'b1;
               end
            end
         end
         ST_WRITE: begin
            wr_data_rdy = !I_stall;
            wr_beat     = wr_data_en && !I_stall;
            if (wr_beat) begin
               if (wr_data_end != last_beat) err_set = 1'b1;
               if (last_beat) state_next = ST_IDLE;
            end
         end
         ST_READ: begin
            // rd_data_end high means the final beat is on the bus now.
            if (rd_data_end) state_next = ST_IDLE;
            else if (rd_wait == '0) rd_issue = 1'b1;
         end
         default: state_next = ST_CALIB;
      endcase
      if (wr_data_en && (state != ST_WRITE)) err_set = 1'b1;
   end

   always_ff @(posedge I_dma_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state               <= ST_CALIB;
         calib_cnt           <= CALIB_LOAD;
         init_calib_complete <= 1'b0;
         base                <= '0;
         len                 <= '0;
         cnt                 <= '0;
         rd_wait             <= '0;
         rd_data_valid       <= 1'b0;
         rd_data_end         <= 1'b0;
         O_proto_err         <= 1'b0;
      end else begin
         state <= state_next;

         if ((state == ST_CALIB) && !init_calib_complete) begin
            if (calib_cnt == '0) init_calib_complete <= 1'b1;
            else calib_cnt <= calib_cnt - 1'b1;
         end

         if (cmd_acc) begin
            base    <= addr[BEAT_SHIFT +: MEM_AW];
            len     <= app_burst_number;
            cnt     <= '0;
            rd_wait <= RD_WAIT_LOAD;
         end else begin
            if (wr_beat || rd_issue) cnt <= cnt + 1'b1;
            if ((state == ST_READ) && (rd_wait != '0)) rd_wait <= rd_wait - 1'b1;
         end

         rd_data_valid <= rd_issue;
         rd_data_end   <= rd_issue && last_beat;

         if (err_set) O_proto_err <= 1'b1;
      end
   end

   ui_bram_be #(
      .DATA_WIDTH (DATA_WIDTH),
      .AW         (MEM_AW)
   ) u_ram (
      .clk   (I_dma_clk),
      .rst_n (I_rst_n),
      .we    (wr_beat),
      .waddr (beat_addr),
      .wbe   (~wr_data_mask),
      .wdata (wr_data),
      .re    (rd_issue),
      .raddr (beat_addr),
      .rdata (rd_data)
   );

endmodule

// File: tb/tb_ddr_ui_responder.sv
module tb_ddr_ui_responder;

   logic          I_dma_clk = 1'b0;
   logic          I_rst_n = 1'b0;
   logic          I_stall = 1'b0;
   logic [2:0]    cmd = 3'b000;
   logic          cmd_en = 1'b0;
   logic [5:0]    app_burst_number = '0;
   logic [25:0]   addr = '0;
   logic          cmd_ready;
   logic          wr_data_en = 1'b0;
   logic          wr_data_end = 1'b0;
   logic [127:0]  wr_data = '0;
   logic [15:0]   wr_data_mask = '0;
   logic          wr_data_rdy;
   logic          rd_data_valid;
   logic          rd_data_end;
   logic [127:0]  rd_data;
   logic          init_calib_complete;
   logic          O_proto_err;

   int tests = 0;
   int fails = 0;

   logic [127:0] mem_m [0:1023];
   logic [127:0] wbuf [0:63];
   logic [15:0]  mbuf [0:63];

   always #5 I_dma_clk = ~I_dma_clk;

   ddr_ui_responder dut (
      .I_dma_clk           (I_dma_clk),
      .I_rst_n             (I_rst_n),
      .I_stall             (I_stall),
      .cmd                 (cmd),
      .cmd_en              (cmd_en),
      .app_burst_number    (app_burst_number),
      .addr                (addr),
      .cmd_ready           (cmd_ready),
      .wr_data_en          (wr_data_en),
      .wr_data_end         (wr_data_end),
      .wr_data             (wr_data),
      .wr_data_mask        (wr_data_mask),
      .wr_data_rdy         (wr_data_rdy),
      .rd_data_valid       (rd_data_valid),
      .rd_data_end         (rd_data_end),
      .rd_data             (rd_data),
      .init_calib_complete (init_calib_complete),
      .O_proto_err         (O_proto_err)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int beat_of(input logic [25:0] a);
      return (int'(a) / 8) % 1024;
   endfunction

   task automatic assert_reset();
      I_rst_n = 1'b0;
      cmd_en = 1'b0; wr_data_en = 1'b0; wr_data_end = 1'b0; I_stall = 1'b0;
      #1;
      chk("rst_valid", rd_data_valid, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_outputs", {cmd_ready, wr_data_rdy, rd_data_end, init_calib_complete, O_proto_err}, 0);
   endtask

   task automatic release_and_calibrate();
      int n;
      repeat (3) @(posedge I_dma_clk);
      #1;
      I_rst_n = 1'b1;
      n = 0;
      while (!init_calib_complete && n < 200) begin
         @(posedge I_dma_clk); #1;
         n++;
         if (n == 32) chk("calib_mid_outputs", {cmd_ready, rd_data_valid, O_proto_err}, 0);
      end
      chk("calib_cycles", n, 64);
      chk("cmd_ready_on_calib_cycle", cmd_ready, 0);
      @(posedge I_dma_clk); #1;
      chk("cmd_ready_after_calib", cmd_ready, 1);
   endtask

   task automatic write_burst(input logic [25:0] a, input int len, input int end_pos, input bit stall_mode);
      int i, cyc, base;
      bit taken;
      base = beat_of(a);
      chk("wr_cmd_ready", cmd_ready, 1);
      cmd = 3'b000; cmd_en = 1'b1; addr = a; app_burst_number = 6'(len);
      @(posedge I_dma_clk); #1;
      cmd_en = 1'b0;
      i = 0; cyc = 0;
      while (i <= len && cyc < 500) begin
         I_stall = stall_mode ? (cyc % 2 == 1) : 1'b0;
         wr_data_en = 1'b1; wr_data = wbuf[i]; wr_data_mask = mbuf[i];
         wr_data_end = (i == end_pos);
         #1;
         chk("wr_data_rdy", wr_data_rdy, !I_stall);
         taken = !I_stall;
         @(posedge I_dma_clk); #1;
         if (taken) begin
            for (int b = 0; b < 16; b++)
               if (!mbuf[i][b]) mem_m[(base + i) % 1024][b*8 +: 8] = wbuf[i][b*8 +: 8];
            i++;
            chk("wr_burst_done", cmd_ready, (i > len));
         end
         cyc++;
      end
      wr_data_en = 1'b0; wr_data_end = 1'b0; I_stall = 1'b0;
      if (cyc >= 500) chk("wr_timeout", 1, 0);
   endtask

   task automatic read_burst(input logic [25:0] a, input int len);
      int base;
      logic [127:0] last;
      bit ev, ee;
      base = beat_of(a);
      last = '0;
      chk("rd_cmd_ready", cmd_ready, 1);
      cmd = 3'b001; cmd_en = 1'b1; addr = a; app_burst_number = 6'(len);
      @(posedge I_dma_clk); #1;
      cmd_en = 1'b0;
      for (int k = 1; k <= len + 5; k++) begin
         @(posedge I_dma_clk); #1;
         ev = (k >= 4) && (k <= 4 + len);
         ee = (k == 4 + len);
         chk("rd_valid", rd_data_valid, ev);
         chk("rd_end", rd_data_end, ee);
         if (ev) begin
            last = mem_m[(base + k - 4) % 1024];
            chk("rd_data", rd_data, last);
         end
      end
      chk("rd_data_hold", rd_data, last);
      chk("rd_idle_after", cmd_ready, 1);
   endtask

   initial begin
      logic [25:0] a;
      int len;

      // Reset and calibration
      assert_reset();
      release_and_calibrate();

      // Loopback at addr 0x40, 4 beats of A0..A3
      for (int i = 0; i < 4; i++) begin
         wbuf[i] = {16{8'(8'hA0 + i)}};
         mbuf[i] = 16'h0000;
      end
      write_burst(26'h40, 3, 3, 1'b0);
      @(posedge I_dma_clk); #1;
      read_burst(26'h40, 3);
      chk("loopback_beat3", mem_m[11], {16{8'hA3}});

      // Byte mask on a single beat
      wbuf[0] = {128{1'b1}}; mbuf[0] = 16'h0000;
      write_burst(26'd800, 0, 0, 1'b0);
      @(posedge I_dma_clk); #1;
      wbuf[0] = '0; mbuf[0] = 16'h00FF;
      write_burst(26'd800, 0, 0, 1'b0);
      @(posedge I_dma_clk); #1;
      read_burst(26'd800, 0);
      chk("byte_mask", rd_data, {64'h0, {64{1'b1}}});

      // Wrap at the top of the RAM with back-pressure
      for (int i = 0; i < 4; i++) begin
         wbuf[i] = {$urandom, $urandom, $urandom, $urandom};
         mbuf[i] = 16'h0000;
      end
      write_burst(26'(1022 * 8), 3, 3, 1'b1);
      @(posedge I_dma_clk); #1;
      read_burst(26'(1022 * 8), 3);
      @(posedge I_dma_clk); #1;
      read_burst(26'h0, 1);
      chk("wrap_beat0", rd_data, wbuf[3]);

      // Randomized bursts: full write, masked overwrite, readback
      for (int it = 0; it < 5; it++) begin
         a = 26'($urandom);
         len = $urandom_range(0, 15);
         for (int i = 0; i <= len; i++) begin
            wbuf[i] = {$urandom, $urandom, $urandom, $urandom};
            mbuf[i] = 16'h0000;
         end
         write_burst(a, len, len, 1'b0);
         @(posedge I_dma_clk); #1;
         for (int i = 0; i <= len; i++) begin
            wbuf[i] = {$urandom, $urandom, $urandom, $urandom};
            mbuf[i] = 16'($urandom);
         end
         write_burst(a, len, len, (it % 2 == 1));
         @(posedge I_dma_clk); #1;
         read_burst(a, len);
         chk("no_err_random", O_proto_err, 0);
      end

      // Illegal command
      cmd = 3'b010; cmd_en = 1'b1; addr = 26'h40; app_burst_number = 6'd0;
      @(posedge I_dma_clk); #1;
      cmd_en = 1'b0;
      chk("illegal_cmd_err", O_proto_err, 1);
      chk("illegal_cmd_idle", {cmd_ready, wr_data_rdy, rd_data_valid}, 3'b100);
      @(posedge I_dma_clk); #1;
      chk("illegal_cmd_still_idle", cmd_ready, 1);

      // Early wr_data_end: burst still takes all 4 beats
      assert_reset();
      release_and_calibrate();
      chk("err_cleared", O_proto_err, 0);
      for (int i = 0; i < 4; i++) begin
         wbuf[i] = {$urandom, $urandom, $urandom, $urandom};
         mbuf[i] = 16'h0000;
      end
      write_burst(26'(500 * 8), 3, 1, 1'b0);
      chk("early_end_err", O_proto_err, 1);
      @(posedge I_dma_clk); #1;
      read_burst(26'(500 * 8), 3);

      // Stray wr_data_en in IDLE
      assert_reset();
      release_and_calibrate();
      wr_data_en = 1'b1;
      @(posedge I_dma_clk); #1;
      wr_data_en = 1'b0;
      chk("stray_wr_en_err", O_proto_err, 1);

      // Reset during beat 2 of a 16-beat read
      assert_reset();
      release_and_calibrate();
      cmd = 3'b001; cmd_en = 1'b1; addr = 26'h40; app_burst_number = 6'd15;
      @(posedge I_dma_clk); #1;
      cmd_en = 1'b0;
      repeat (5) @(posedge I_dma_clk);
      #1;
      chk("midread_beat2_valid", rd_data_valid, 1);
      #2;
      assert_reset();
      repeat (2) @(posedge I_dma_clk);
      #1;
      chk("midread_no_beats", rd_data_valid, 0);
      release_and_calibrate();
      chk("midread_no_stray_beat", rd_data_valid, 0);
      read_burst(26'h40, 3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
